// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit slice resolved per stage,
// registered carry between stages, valid/ready on both sides with full backpressure.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipelined_addsub: WIDTH must be a multiple of SEG");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = cin ^ sub;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [SEG:0]     slice_d;
    logic [WIDTH-1:0] sum_d;
    logic             adv;

    if (gi == 0) begin : g_src
      assign a_in = a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_src
      assign a_in = g_stage[gi-1].g_ops.a_q;
      assign b_in = g_stage[gi-1].g_ops.b_q;
      assign s_in = g_stage[gi-1].sum_q;
      assign c_in = g_stage[gi-1].carry_q;
      assign v_in = g_stage[gi-1].valid_q;
    end

    // A stage moves when it is empty or its successor moves, so bubbles collapse.
    if (gi == STAGES - 1) begin : g_adv
      assign adv = !valid_q || out_ready;
    end else begin : g_adv
      assign adv = !valid_q || g_stage[gi+1].adv;
    end

    assign slice_d = {1'b0, a_in[gi*SEG +: SEG]} + {1'b0, b_in[gi*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    always_comb begin
      sum_d                 = s_in;
      sum_d[gi*SEG +: SEG]  = slice_d[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        valid_q <= v_in;
        if (v_in) begin
          sum_q   <= sum_d;
          carry_q <= slice_d[SEG];
        end
      end
    end

    if (gi < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end
  end

  // Flags are formed while the final slice resolves and registered alongside sum.
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  assign ovf_d  = (g_stage[STAGES-1].a_in[WIDTH-1] == g_stage[STAGES-1].b_in[WIDTH-1])
               && (g_stage[STAGES-1].sum_d[WIDTH-1] != g_stage[STAGES-1].a_in[WIDTH-1]);
  assign zero_d = (g_stage[STAGES-1].sum_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (g_stage[STAGES-1].adv && g_stage[STAGES-1].v_in) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 32/8, 16/4 and 16/16 configurations.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin, sub;

  logic        in_valid, out_ready;
  logic [31:0] a32, b32;
  logic        in_ready32, out_valid32, co32, ov32, z32;
  logic [31:0] sum32;

  logic        in_valid16, ready16;
  logic [15:0] a16, b16;
  logic        ir_a, ov_a, co_a, of_a, z_a;
  logic [15:0] s_a;
  logic        ir_b, ov_b, co_b, of_b, z_b;
  logic [15:0] s_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin), .sub(sub), .out_valid(out_valid32),
    .out_ready(out_ready), .sum(sum32), .carry_out(co32), .overflow(ov32), .zero(z32)
  );

  pipelined_addsub #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(ir_a),
    .a(a16), .b(b16), .cin(cin), .sub(sub), .out_valid(ov_a),
    .out_ready(ready16), .sum(s_a), .carry_out(co_a), .overflow(of_a), .zero(z_a)
  );

  pipelined_addsub #(.WIDTH(16), .SEG(16)) dut16s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(ir_b),
    .a(a16), .b(b16), .cin(cin), .sub(sub), .out_valid(ov_b),
    .out_ready(ready16), .sum(s_b), .carry_out(co_b), .overflow(of_b), .zero(z_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 32-bit unit and check latency and result.
  task automatic op32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input logic ts, input logic [31:0] es,
                      input logic ec, input logic eo, input logic ez);
    int n;
    a32 = ta; b32 = tb_; cin = tc; sub = ts;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready32, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid32 && n < 20) begin
      tick();
      n++;
    end
    $display("op %s: %h %s %h cin=%0d -> sum=%h c=%0d v=%0d z=%0d after %0d edges",
             tag, ta, ts ? "-" : "+", tb_, tc, sum32, co32, ov32, z32, n);
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum32, es);
    check({tag, "_carry"}, co32, ec);
    check({tag, "_ovf"}, ov32, eo);
    check({tag, "_zero"}, z32, ez);
    tick();
  endtask

  logic [31:0] exp_tab [6];
  int acc_idx, out_idx, n16;

  initial begin
    exp_tab = '{32'd1, 32'd12, 32'd23, 32'd34, 32'd45, 32'd56};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a32 = '0; b32 = '0;
    cin = 1'b0; sub = 1'b0; in_valid16 = 1'b0; ready16 = 1'b1; a16 = '0; b16 = '0;
    tick(); tick();
    check("rst_out_valid", out_valid32, 1'b0);
    check("rst_sum", sum32, 32'h0);
    check("rst_flags", {co32, ov32, z32}, 3'b000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready32, 1'b1);
    tick();

    op32("t1", 32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    op32("t2a", 32'hffffffff, 32'h80000000, 1'b0, 1'b0, 32'h7fffffff, 1'b1, 1'b1, 1'b0);
    op32("t2b", 32'h00000002, 32'h00000005, 1'b0, 1'b1, 32'hfffffffd, 1'b0, 1'b0, 1'b0);
    op32("t2c", 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    op32("t2d", 32'h00000009, 32'h00000004, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0);

    // Stream of six adds with the output stalled for cycles 3..7.
    acc_idx = 0; out_idx = 0; cin = 1'b0; sub = 1'b0;
    for (int t = 0; t < 20; t++) begin
      out_ready = !(t >= 3 && t <= 7);
      in_valid  = (acc_idx < 6);
      a32 = acc_idx + 1;
      b32 = 10 * acc_idx;
      #1;
      if (t <= 9) check($sformatf("t3_in_ready_c%0d", t), in_ready32, !(t >= 4 && t <= 7));
      if (t >= 5 && t <= 7) begin
        check($sformatf("t3_hold_valid_c%0d", t), out_valid32, 1'b1);
        check($sformatf("t3_hold_sum_c%0d", t), sum32, 32'd1);
      end
      if (out_valid32 && out_ready) begin
        $display("t3 result %0d = %0d at cycle %0d", out_idx, sum32, t);
        if (out_idx < 6) check($sformatf("t3_res%0d", out_idx), sum32, exp_tab[out_idx]);
        out_idx++;
      end
      if (in_valid && in_ready32) acc_idx++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_accepted", acc_idx, 6);
    check("t3_delivered", out_idx, 6);

    // Fill with the output stalled, then pass exactly one result through.
    out_ready = 1'b0; b32 = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a32 = 100 + i;
      #1;
      check($sformatf("t4_fill%0d_ready", i), in_ready32, 1'b1);
      tick();
    end
    a32 = 104;
    #1;
    check("t4_full_blocked", in_ready32, 1'b0);
    check("t4_head_valid", out_valid32, 1'b1);
    check("t4_head_sum", sum32, 32'd100);
    tick();
    check("t4_head_held", sum32, 32'd100);
    out_ready = 1'b1;
    #1;
    check("t4_pass_ready", in_ready32, 1'b1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("t4_after_valid", out_valid32, 1'b1);
    check("t4_after_sum", sum32, 32'd101);
    check("t4_still_full", in_ready32, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("t4 drain %0d: valid=%0d sum=%0d", k, out_valid32, sum32);
      check($sformatf("t4_drain%0d_valid", k), out_valid32, 1'b1);
      check($sformatf("t4_drain%0d_sum", k), sum32, 32'd101 + k);
      tick();
    end
    check("t4_empty", out_valid32, 1'b0);

    // Asynchronous reset with three operations in flight.
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a32 = (i == 0) ? 32'hffffffff : i;
      b32 = (i == 0) ? 32'h80000000 : i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t5_pre_valid", out_valid32, 1'b1);
    check("t5_pre_sum", sum32, 32'h7fffffff);
    check("t5_pre_flags", {co32, ov32}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid32, 1'b0);
    check("t5_async_sum", sum32, 32'h0);
    check("t5_async_flags", {co32, ov32, z32}, 3'b000);
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("t5_rel_ready", in_ready32, 1'b1);
    tick();
    check("t5_no_stale", out_valid32, 1'b0);
    op32("t5_next", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

    // 16-bit configurations: four 4-bit stages and a single-stage unit.
    a16 = 16'hffff; b16 = 16'h0001; cin = 1'b1; sub = 1'b0; in_valid16 = 1'b1;
    #1;
    check("t6_ready", {ir_a, ir_b}, 2'b11);
    tick();
    in_valid16 = 1'b0;
    $display("t6 single-stage: valid=%0d sum=%h c=%0d v=%0d", ov_b, s_b, co_b, of_b);
    check("t6s_valid", ov_b, 1'b1);
    check("t6s_sum", s_b, 16'h0001);
    check("t6s_flags", {co_b, of_b, z_b}, 3'b100);
    check("t6_seg4_early", ov_a, 1'b0);
    n16 = 1;
    while (!ov_a && n16 < 20) begin
      tick();
      n16++;
    end
    $display("t6 seg4: sum=%h c=%0d v=%0d after %0d edges", s_a, co_a, of_a, n16);
    check("t6_latency", n16, 4);
    check("t6_sum", s_a, 16'h0001);
    check("t6_flags", {co_a, of_a, z_a}, 3'b100);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
